hazard_scoreboard: RTL and testbench

- Parametrised successor to the single-cycle combinational hazard detector in the ARM pipeline's ID stage.
- Keeps a shadow pipeline of in-flight writers (EXE, MEM, ... up to STAGES deep) and compares the ID-stage sources against every valid entry.
- Drives the IF/ID freeze (stall), the EXE NOP insert (bubble), and forwarding selects. Also holds a saturating stall-cycle counter.
- Holds its tracking state while the memory stage is busy (SRAM wait).

---
 rtl/hazard_scoreboard.sv | 109 ++++++++++
 tb/tb_hazard_scoreboard.sv | 127 ++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: ID-stage hazard detector tracking STAGES in-flight writers
// Ports:
//   clk, rst (sync, active-low)
//   id_valid/id_src1/id_src2/id_two_src/id_dest/id_wb_en/id_mem_read : ID-stage instruction
//   flush : kill the ID instruction; mem_busy : freeze the whole pipe
//   stall/bubble : IF/ID freeze and ID/EXE NOP insert
//   fwd_sel1/fwd_sel2 : 0 = register file, k = forward from entry k-1
//   stall_count : saturating stall-cycle counter
// Optional feature macro: HAZARD_FWD_EN (forwarding, load-use-only stalls)
module hazard_scoreboard #(
    parameter int REG_AW = 4,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_src1,
    input  logic [REG_AW-1:0] id_src2,
    input  logic              id_two_src,
    input  logic [REG_AW-1:0] id_dest,
    input  logic              id_wb_en,
    input  logic              id_mem_read,
    input  logic              flush,
    input  logic              mem_busy,
    output logic              stall,
    output logic              bubble,
    output logic [2:0]        fwd_sel1,
    output logic [2:0]        fwd_sel2,
    output logic [CNT_W-1:0]  stall_count
);
    logic [STAGES-1:0]             valid_q, valid_d, wb_q, wb_d;
    logic [STAGES-1:0][REG_AW-1:0] dest_q, dest_d;
    // Only the EXE entry's load flag is ever consulted, so only it is kept
    logic                          mr0_q, mr0_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [STAGES-1:0]             match1, match2;
    logic                          raw, load_use, haz;
    logic [2:0]                    f1, f2;

    always_comb begin
        match1 = '0;
        match2 = '0;
        for (int k = 0; k < STAGES; k++) begin
            match1[k] = valid_q[k] & wb_q[k] & (dest_q[k] == id_src1) & id_valid;
            match2[k] = valid_q[k] & wb_q[k] & (dest_q[k] == id_src2) & id_valid & id_two_src;
        end
        raw      = |{match1, match2};
        load_use = (match1[0] | match2[0]) & mr0_q;
        f1 = '0;
        f2 = '0;
`ifdef HAZARD_FWD_EN
        haz = load_use;
        // Scan oldest to youngest so the youngest match is the one left standing
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (match1[k]) f1 = 3'(k + 1);
            if (match2[k]) f2 = 3'(k + 1);
        end
        if (haz) begin
            f1 = '0;
            f2 = '0;
        end
`else
        // load_use is a subset of raw; folding it in keeps the same function
        haz = raw | load_use;
`endif
        stall    = rst & (mem_busy | (haz & ~flush));
        bubble   = rst & haz & ~mem_busy & ~flush;
        fwd_sel1 = rst ? f1 : 3'd0;
        fwd_sel2 = rst ? f2 : 3'd0;
    end

    always_comb begin
        valid_d = valid_q;
        wb_d    = wb_q;
        dest_d  = dest_q;
        mr0_d   = mr0_q;
        if (!mem_busy) begin
            for (int k = STAGES - 1; k > 0; k--) begin
                valid_d[k] = valid_q[k-1];
                wb_d[k]    = wb_q[k-1];
                dest_d[k]  = dest_q[k-1];
            end
            valid_d[0] = id_valid & ~flush & ~stall;
            wb_d[0]    = id_wb_en;
            dest_d[0]  = id_dest;
            mr0_d      = id_mem_read;
        end
        cnt_d = (stall && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
            wb_q    <= '0;
            dest_q  <= '0;
            mr0_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            wb_q    <= wb_d;
            dest_q  <= dest_d;
            mr0_q   <= mr0_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stall_count = cnt_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: randomized check of hazard_scoreboard against a queue-based model
module tb_hazard_scoreboard;
    localparam int AW = 4, ST = 3, CW = 4;

    logic clk = 1'b0, rst = 1'b0;
    logic id_valid = 0, id_two_src = 0, id_wb_en = 0, id_mem_read = 0, flush = 0, mem_busy = 0;
    logic [AW-1:0] id_src1 = 0, id_src2 = 0, id_dest = 0;
    logic stall, bubble;
    logic [2:0] fwd_sel1, fwd_sel2;
    logic [CW-1:0] stall_count;

    hazard_scoreboard #(.REG_AW(AW), .STAGES(ST), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_two_src(id_two_src), .id_dest(id_dest), .id_wb_en(id_wb_en),
        .id_mem_read(id_mem_read), .flush(flush), .mem_busy(mem_busy), .stall(stall),
        .bubble(bubble), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic v; logic [AW-1:0] d; logic w; logic r;} ent_t;
    ent_t pipe[$];
    int total = 0, passed = 0, cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        else passed++;
    endtask

    task automatic clear_model();
        pipe.delete();
        for (int i = 0; i < ST; i++) pipe.push_back('0);
        cnt = 0;
    endtask

    // One cycle: inputs already set before negedge settle; check, then advance the model on posedge
    task automatic cycle();
        int m1, m2;
        logic haz, e_stall, e_bub;
        logic [2:0] e1, e2;
        ent_t n;
        #1;
        m1 = -1;
        m2 = -1;
        for (int k = 0; k < ST; k++) begin
            if (m1 < 0 && id_valid && pipe[k].v && pipe[k].w && pipe[k].d == id_src1) m1 = k;
            if (m2 < 0 && id_valid && id_two_src && pipe[k].v && pipe[k].w && pipe[k].d == id_src2) m2 = k;
        end
`ifdef HAZARD_FWD_EN
        haz = (m1 == 0 || m2 == 0) && pipe[0].r;
        e1 = (haz || m1 < 0) ? 3'd0 : 3'(m1 + 1);
        e2 = (haz || m2 < 0) ? 3'd0 : 3'(m2 + 1);
`else
        haz = (m1 >= 0 || m2 >= 0);
        e1 = 0;
        e2 = 0;
`endif
        e_stall = rst && (mem_busy || (haz && !flush));
        e_bub = rst && haz && !mem_busy && !flush;
        if (!rst) begin
            e1 = 0;
            e2 = 0;
        end
        check("stall", 32'(stall), 32'(e_stall));
        check("bubble", 32'(bubble), 32'(e_bub));
        check("fwd_sel1", 32'(fwd_sel1), 32'(e1));
        check("fwd_sel2", 32'(fwd_sel2), 32'(e2));
        check("stall_count", 32'(stall_count), 32'(cnt));
        @(posedge clk);
        if (!rst) clear_model();
        else begin
            if (e_stall && cnt < (1 << CW) - 1) cnt++;
            if (!mem_busy) begin
                n.v = id_valid && !flush && !e_stall;
                n.d = id_dest;
                n.w = id_wb_en;
                n.r = id_mem_read;
                pipe.push_front(n);
                void'(pipe.pop_back());
            end
        end
        @(negedge clk);
    endtask

    task automatic randomize_inputs(input int busy_pct);
        rst = ($urandom_range(0, 39) != 0);
        id_valid = ($urandom_range(0, 9) != 0);
        id_src1 = AW'($urandom_range(0, 3));
        id_src2 = AW'($urandom_range(0, 3));
        id_dest = AW'($urandom_range(0, 3));
        id_two_src = $urandom_range(0, 1) == 1;
        id_wb_en = ($urandom_range(0, 3) != 0);
        id_mem_read = $urandom_range(0, 2) == 0;
        flush = ($urandom_range(0, 7) == 0);
        mem_busy = ($urandom_range(0, 99) < busy_pct);
    endtask

    initial begin
        rst = 1'b0;
        repeat (2) @(posedge clk);
        clear_model();
        @(negedge clk);
        cycle();
        rst = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            randomize_inputs(i < 1500 ? 15 : 2);
            cycle();
        end
        // Long freeze drives the counter into saturation
        rst = 1'b1;
        mem_busy = 1'b1;
        repeat (20) cycle();
        for (int i = 0; i < 500; i++) begin
            randomize_inputs(10);
            cycle();
        end
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        mem_busy = 1'b0;
        id_valid = 1'b0;
        cycle();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
